polar_encoder: RTL and testbench
================================

POLAR_ENCODER -- requirements
Module: polar_encoder

Interface
REQ-001 SHALL have parameter N_MAX, default 512, maximum code length.
REQ-002 SHALL have parameter LOGN_MAX, default 9, log2(N_MAX).
REQ-003 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, one-cycle request to begin a codeword; honoured only in IDLE.
REQ-006 SHALL have port n_sel, input, 2, code length: 00=128, 01=256, 10=512, 11=reserved (treated as 128); sampled with start.
REQ-007 SHALL have port in_valid, input, 1, u bit presented.
REQ-008 SHALL have port in_ready, output, 1, encoder accepts a u bit.
REQ-009 SHALL have port u_in, input, 1, message bit u(i), i ascending from 0.
REQ-010 SHALL have port frozen_in, input, 1, 1 = index i is frozen.
REQ-011 SHALL have port out_valid, output, 1, codeword bit presented.
REQ-012 SHALL have port out_ready, input, 1, downstream accepts codeword bit.
REQ-013 SHALL have port x_out, output, 1, codeword bit x(j), j ascending from 0.
REQ-014 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, ENCODE, OUTPUT.
REQ-016 SHALL go IDLE->LOAD on start; latch N, clear the N_MAX-bit working register and the index counter.
REQ-017 SHALL assert in_ready only in LOAD; a bit transfers when in_valid and in_ready are both high.
REQ-018 SHALL store u_in & ~frozen_in at index i per transfer (frozen positions forced to 0), then increment i.
REQ-019 SHALL go LOAD->ENCODE on the transfer of index N-1; stage counter s=0.
REQ-020 SHALL in ENCODE perform one butterfly stage per cycle: for every j<N with bit s of j clear, x[j] <= x[j] ^ x[j+2^s]; other entries unchanged.
REQ-021 SHALL run exactly log2(N) ENCODE cycles (7/8/9), then enter OUTPUT with index j=0; the result equals u*F^(tensor n), F=[[1,0],[1,1]], no bit reversal.
REQ-022 SHALL in OUTPUT assert out_valid with x_out = x[j]; on out_valid & out_ready increment j; after transferring j=N-1 return to IDLE.
REQ-023 SHALL hold x_out stable while out_valid is high and out_ready is low.
REQ-024 SHALL ignore start when not in IDLE; in_valid outside LOAD has no effect.
REQ-025 SHALL keep entries at indices >= N at 0 for N < N_MAX.
REQ-026 SHALL be able to accept start in the cycle after the final OUTPUT transfer (back-to-back codewords).

Reset
REQ-027 SHALL on rst_n low asynchronously enter IDLE and clear the working register and all counters; in_ready=0, out_valid=0, x_out=0, busy=0.
REQ-028 SHALL abandon any partial codeword when reset occurs mid-LOAD, mid-ENCODE or mid-OUTPUT, with no output after release until a new start.

Structure
REQ-029 SHALL take N_MAX, LOGN_MAX, n_sel encodings and FSM state encodings from the shared polar package used by the decoder blocks.
REQ-030 SHALL contain one sub-module, polar_enc_stage: combinational single-stage butterfly taking the register, s and N, returning the next register.

Verification
REQ-031 SHALL test N=128 with all frozen_in=1 and u_in=1 -> 128 output bits all 0, state back to IDLE.
REQ-032 SHALL test N=128 with u(0)=1 unfrozen and all others 0 -> x(0)=1, x(1..127)=0.
REQ-033 SHALL test N=512 with u(511)=1 unfrozen and all others 0 -> all 512 bits = 1, ENCODE lasting exactly 9 cycles.
REQ-034 SHALL test N=256 random u/frozen with out_ready toggled every other cycle -> bitstream matches the reference model, no drops or duplicates.
REQ-035 SHALL test rst_n pulsed low at LOAD index 60, then a new N=128 codeword -> the new codeword is correct and no stale bits appear.
REQ-036 SHALL test start pulsed during ENCODE -> ignored, and the current codeword completes unchanged.

Source files
------------

// File: rtl/polar_pkg.sv
// Shared polar-code definitions: size limits, n_sel encodings, encoder FSM
// states and the code-length decode used by the encoder and decoder blocks.
package polar_pkg;

  localparam int N_MAX_DEF    = 512;
  localparam int LOGN_MAX_DEF = 9;

  typedef enum logic [1:0] {
    NSEL_128  = 2'b00,
    NSEL_256  = 2'b01,
    NSEL_512  = 2'b10,
    NSEL_RSVD = 2'b11
  } nsel_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_ENCODE = 2'd2,
    ST_OUTPUT = 2'd3
  } enc_state_e;

  // log2 of the code length; the reserved encoding falls back to 128.
  function automatic int nsel_logn(input logic [1:0] sel);
    case (nsel_e'(sel))
      NSEL_256: return 8;
      NSEL_512: return 9;
      default:  return 7;
    endcase
  endfunction

endpackage

// File: rtl/polar_encoder_if.sv
// Handshake bundle of the polar encoder: start/length control, u-bit input
// stream, codeword output stream and busy status.
interface polar_encoder_if;
  logic       start;
  logic [1:0] n_sel;
  logic       in_valid;
  logic       in_ready;
  logic       u_in;
  logic       frozen_in;
  logic       out_valid;
  logic       out_ready;
  logic       x_out;
  logic       busy;

  modport master (
    output start, n_sel, in_valid, u_in, frozen_in, out_ready,
    input  in_ready, out_valid, x_out, busy
  );

  modport slave (
    input  start, n_sel, in_valid, u_in, frozen_in, out_ready,
    output in_ready, out_valid, x_out, busy
  );
endinterface

// File: rtl/polar_enc_stage.sv
// One butterfly stage of the polar transform: for each j < n with bit s of j
// clear, x[j] ^= x[j + 2^s]. Every stage is built in parallel and s selects.
module polar_enc_stage #(
  parameter int N_MAX    = 512,
  parameter int LOGN_MAX = 9,
  parameter int SW       = 4
) (
  input  logic [N_MAX-1:0]  x_in,
  input  logic [SW-1:0]     s,
  input  logic [LOGN_MAX:0] n,
  output logic [N_MAX-1:0]  x_out
);

  logic [N_MAX-1:0] stage_res [LOGN_MAX];

  for (genvar k = 0; k < LOGN_MAX; k++) begin : g_stage
    for (genvar j = 0; j < N_MAX; j++) begin : g_bit
      if (((j >> k) & 1) == 0) begin : g_upper
        assign stage_res[k][j] = (int'(n) > j) ? (x_in[j] ^ x_in[j + (1 << k)]) : x_in[j];
      end else begin : g_lower
        assign stage_res[k][j] = x_in[j];
      end
    end
  end

  // Pick the butterfly result for the current stage; out-of-range s passes through.
  always_comb begin
    x_out = x_in;
    if (int'(s) < LOGN_MAX) x_out = stage_res[s];
  end

endmodule

// File: rtl/polar_encoder.sv
// Polar encoder: loads N message bits (frozen positions forced to 0), applies
// log2(N) in-place butterfly stages, then streams the codeword out bit by bit.
module polar_encoder
  import polar_pkg::*;
#(
  parameter int N_MAX    = N_MAX_DEF,
  parameter int LOGN_MAX = LOGN_MAX_DEF
) (
  input logic            clk,
  input logic            rst_n,
  polar_encoder_if.slave bus
);

  localparam int SW = $clog2(LOGN_MAX + 1);

  enc_state_e          state, state_nxt;
  logic [N_MAX-1:0]    x_reg, x_stage;
  logic [LOGN_MAX:0]   n_len;
  logic [SW-1:0]       logn, s_cnt;
  logic [LOGN_MAX-1:0] idx;
  logic                in_xfer, out_xfer, idx_last, s_last;

  assign in_xfer  = (state == ST_LOAD)   && bus.in_valid;
  assign out_xfer = (state == ST_OUTPUT) && bus.out_ready;
  assign idx_last = ({1'b0, idx} == (n_len - 1'b1));
  assign s_last   = (s_cnt == (logn - 1'b1));

  polar_enc_stage #(
    .N_MAX    (N_MAX),
    .LOGN_MAX (LOGN_MAX),
    .SW       (SW)
  ) u_stage (
    .x_in  (x_reg),
    .s     (s_cnt),
    .n     (n_len),
    .x_out (x_stage)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.x_out     = 1'b0;
    bus.busy      = 1'b1;
    case (state)
      ST_IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        bus.in_ready = 1'b1;
        if (in_xfer && idx_last) state_nxt = ST_ENCODE;
      end
      ST_ENCODE: begin
        if (s_last) state_nxt = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        bus.out_valid = 1'b1;
        bus.x_out     = x_reg[idx];
        if (out_xfer && idx_last) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Working register, code length and the shared bit/stage counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_reg <= '0;
      n_len <= '0;
      logn  <= '0;
      s_cnt <= '0;
      idx   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            logn  <= SW'(nsel_logn(bus.n_sel));
            n_len <= (LOGN_MAX + 1)'(1) << nsel_logn(bus.n_sel);
            x_reg <= '0;
            idx   <= '0;
            s_cnt <= '0;
          end
        end
        ST_LOAD: begin
          if (in_xfer) begin
            x_reg[idx] <= bus.u_in & ~bus.frozen_in;
            idx        <= idx_last ? '0 : idx + 1'b1;
          end
          s_cnt <= '0;
        end
        ST_ENCODE: begin
          x_reg <= x_stage;
          s_cnt <= s_cnt + 1'b1;
          if (s_last) idx <= '0;
        end
        ST_OUTPUT: begin
          if (out_xfer) idx <= idx_last ? '0 : idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_polar_encoder.sv
// Bench for polar_encoder: codewords are predicted from the generator matrix
// (x_j = XOR of u_i over every i whose bit set contains j's) and compared
// bit by bit against the streamed output.
module tb_polar_encoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  polar_encoder_if bus ();

  polar_encoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  bit   u_arr [512];
  bit   f_arr [512];
  bit   mdl   [512];
  bit   exp_q [$];
  int   rx_n, rx_ones;
  logic rx_first;
  int   rdy_mode = 0;
  bit   hold_pending = 1'b0;
  logic held_x;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int len_of(input logic [1:0] sel);
    case (sel)
      2'b01:   return 256;
      2'b10:   return 512;
      default: return 128;
    endcase
  endfunction

  function automatic int logn_of(input logic [1:0] sel);
    case (sel)
      2'b01:   return 8;
      2'b10:   return 9;
      default: return 7;
    endcase
  endfunction

  // Generator-matrix reference: G[i][j] = 1 iff j's bits are a subset of i's.
  function automatic void model(input int n);
    for (int j = 0; j < 512; j++) begin
      bit acc;
      acc = 1'b0;
      if (j < n)
        for (int i = 0; i < n; i++)
          if ((i & j) == j) acc ^= (u_arr[i] & ~f_arr[i]);
      mdl[j] = acc;
    end
  endfunction

  task automatic set_random();
    for (int i = 0; i < 512; i++) begin
      u_arr[i] = 1'($urandom_range(0, 1));
      f_arr[i] = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic set_zero();
    for (int i = 0; i < 512; i++) begin
      u_arr[i] = 1'b0;
      f_arr[i] = 1'b0;
    end
  endtask

  // Output compare: every transfer must match the next predicted bit, and a
  // stalled bit must not change before it is taken.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_pending = 1'b0;
        continue;
      end
      if (hold_pending) check("stall_hold", bus.x_out, held_x);
      hold_pending = 1'b0;
      if (bus.out_valid) begin
        if (bus.out_ready) begin
          if (exp_q.size() == 0) begin
            check("stray_output", 1, 0);
          end else begin
            check("x_bit", bus.x_out, exp_q.pop_front());
            if (rx_n == 0) rx_first = bus.x_out;
            if (bus.x_out === 1'b1) rx_ones++;
            rx_n++;
          end
        end else begin
          hold_pending = 1'b1;
          held_x       = bus.x_out;
        end
      end
    end
  end

  // Downstream ready: 0 = always ready, 1 = toggling, 2 = random.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1:       bus.out_ready = ~bus.out_ready;
        2:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = 1'b1;
      endcase
    end
  end

  // Runs one codeword from the current u/frozen arrays. Entered and left at
  // 1 time unit after a rising edge; on leaving, the last bit has just been taken.
  task automatic run_cw(input logic [1:0] sel, input bit gaps, input bit poke_start,
                        input int abort_at);
    int n, cnt, b;
    n       = len_of(sel);
    rx_n    = 0;
    rx_ones = 0;
    if (abort_at < 0) begin
      model(n);
      for (int j = 0; j < n; j++) exp_q.push_back(mdl[j]);
    end
    bus.start = 1'b1;
    bus.n_sel = sel;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i == abort_at) begin
        rst_n = 1'b0;
        #2;
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_x_out", bus.x_out, 0);
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) begin @(posedge clk); #1; end
        check("abort_idle", bus.busy, 0);
        return;
      end
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
      end
      bus.in_valid  = 1'b1;
      bus.u_in      = u_arr[i];
      bus.frozen_in = f_arr[i];
      @(negedge clk);
      if (bus.in_ready !== 1'b1) begin
        check("load_ready", bus.in_ready, 1);
        bus.in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    // Leave in_valid high with junk bits during ENCODE when poking start.
    bus.in_valid  = poke_start;
    bus.u_in      = 1'b1;
    bus.frozen_in = 1'b0;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (bus.out_valid || cnt > 40) break;
      cnt++;
      if (poke_start && cnt == 3) begin
        bus.start = 1'b1;
        bus.n_sel = ~sel;
      end else if (cnt == 4) begin
        bus.start = 1'b0;
      end
    end
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    check("encode_cycles", cnt, logn_of(sel));
    @(posedge clk); #1;
    b = 0;
    while (exp_q.size() != 0 && b < 5000) begin
      @(posedge clk); #1;
      b++;
    end
    if (b >= 5000) check("drain_timeout", exp_q.size(), 0);
    check("rx_count", rx_n, n);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start     = 1'b0;
    bus.n_sel     = 2'b00;
    bus.in_valid  = 1'b0;
    bus.u_in      = 1'b0;
    bus.frozen_in = 1'b0;
    rst_n         = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", bus.in_ready, 0);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_x_out", bus.x_out, 0);
    check("reset_busy", bus.busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Hand-computed model pins: u = (1,1,0,...) gives x = (0,1,0,...).
    set_zero();
    u_arr[0] = 1'b1;
    u_arr[1] = 1'b1;
    model(128);
    check("model_x0", mdl[0], 0);
    check("model_x1", mdl[1], 1);
    check("model_x2", mdl[2], 0);
    check("model_x3", mdl[3], 0);

    // N=128, every position frozen with u=1: all-zero codeword.
    for (int i = 0; i < 512; i++) begin
      u_arr[i] = 1'b1;
      f_arr[i] = 1'b1;
    end
    run_cw(2'b00, 1'b0, 1'b0, -1);
    check("all_frozen_ones", rx_ones, 0);
    check("all_frozen_idle", bus.busy, 0);

    // N=128, only u(0)=1: x(0)=1 and nothing else.
    set_zero();
    u_arr[0] = 1'b1;
    run_cw(2'b00, 1'b0, 1'b0, -1);
    check("unit0_first", rx_first, 1);
    check("unit0_ones", rx_ones, 1);

    // N=512, only u(511)=1: every codeword bit is 1.
    set_zero();
    u_arr[511] = 1'b1;
    run_cw(2'b10, 1'b0, 1'b0, -1);
    check("unit511_ones", rx_ones, 512);

    // N=256 random with out_ready toggling every cycle.
    rdy_mode = 1;
    set_random();
    run_cw(2'b01, 1'b1, 1'b0, -1);
    rdy_mode = 0;

    // Reset at LOAD index 60, then a fresh N=128 codeword.
    set_random();
    run_cw(2'b00, 1'b0, 1'b0, 60);
    set_random();
    run_cw(2'b00, 1'b0, 1'b0, -1);

    // N=512 random, start and in_valid poked during ENCODE, random out_ready.
    rdy_mode = 2;
    set_random();
    run_cw(2'b10, 1'b1, 1'b1, -1);

    // Reserved length encoding then a back-to-back N=256 codeword.
    rdy_mode = 0;
    set_random();
    run_cw(2'b11, 1'b0, 1'b0, -1);
    set_random();
    run_cw(2'b01, 1'b0, 1'b0, -1);
    check("final_idle", bus.busy, 0);

    repeat (4) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
